// File: rtl/a2d_spi_master.sv
// SPI master for the ADC128S A2D: a command frame selects the channel, a second
// identical frame clocks back that channel's 12-bit conversion result.
module a2d_spi_master #(
    parameter int SCLK_DIV_W = 5,
    parameter int GAP_CLKS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    // Load value gives a front porch of 2^(W-2)+1 clks with SCLK high.
    localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_SMPL = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_SHFT = '1;

    typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} state_t;

    state_t                  state, next_state;
    logic [SCLK_DIV_W-1:0]   div;
    logic [3:0]              bit_cnt;
    logic [15:0]             shift_reg;
    logic [2:0]              chnnl_l;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    miso_smpl;
    logic                    first_strb;

    logic smpl, shft, last_shift;
    logic start_tx, latch_cmd, capture;
    logic [15:0] cmd_word;

    assign smpl       = !SS_n && (div == DIV_SMPL);
    assign shft       = !SS_n && (div == DIV_SHFT);
    assign last_shift = shft && !first_strb && (bit_cnt == 4'hF);
    assign cmd_word   = {2'b00, (latch_cmd ? chnnl : chnnl_l), 11'h000};

    // SCLK is forced high whenever SS_n is high, including straight out of reset.
    assign SCLK = SS_n | div[SCLK_DIV_W-1];
    assign MOSI = shift_reg[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        start_tx   = 1'b0;
        latch_cmd  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: if (strt_cnv) begin
                next_state = TX1;
                start_tx   = 1'b1;
                latch_cmd  = 1'b1;
            end
            TX1: if (last_shift) next_state = GAP;
            GAP: if (gap_cnt == GAP_LAST) begin
                next_state = TX2;
                start_tx   = 1'b1;
            end
            TX2: if (last_shift) begin
                next_state = IDLE;
                capture    = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n       <= 1'b1;
            div        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            chnnl_l    <= '0;
            gap_cnt    <= '0;
            miso_smpl  <= 1'b0;
            first_strb <= 1'b0;
            cnv_cmplt  <= 1'b0;
            res        <= '0;
        end else begin
            if (latch_cmd) chnnl_l <= chnnl;

            if (start_tx) begin
                shift_reg  <= cmd_word;
                SS_n       <= 1'b0;
                div        <= DIV_LOAD;
                bit_cnt    <= '0;
                first_strb <= 1'b1;
            end else if (!SS_n) begin
                div <= div + SCLK_DIV_W'(1);
                if (smpl) miso_smpl <= MISO;
                // The falling edge at the end of the front porch carries no data.
                if (shft) begin
                    if (first_strb) begin
                        first_strb <= 1'b0;
                    end else begin
                        shift_reg <= {shift_reg[14:0], miso_smpl};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                end
                if (last_shift) begin
                    SS_n <= 1'b1;
                    div  <= DIV_LOAD;
                end
            end

            if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else              gap_cnt <= '0;

            if (latch_cmd) begin
                cnv_cmplt <= 1'b0;
            end else if (capture) begin
                cnv_cmplt <= 1'b1;
                res       <= {shift_reg[10:0], miso_smpl};
            end
        end
    end

endmodule

// File: tb/tb_a2d_spi_master.sv
// Bench for a2d_spi_master: a frame-level ADC128S model answers each SS_n window
// and records what the master sent; each scenario task checks its own results.
module tb_a2d_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        MISO;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n, SCLK, MOSI;

    int checks = 0;
    int failures = 0;

    logic [11:0] analog [8];
    bit          forced_mode = 1'b0;
    logic [15:0] forced_q [$];

    // Per-window records pushed by the ADC model when SS_n rises.
    int          win_len_q [$];
    int          win_rise_q [$];
    logic [15:0] win_cmd_q [$];
    int          idle_toggles = 0;

    bit          in_win, prev_sclk, prev_ss;
    int          win_len, rises;
    logic [15:0] mosi_word, miso_word;
    logic [2:0]  adc_next_ch;

    a2d_spi_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    // ADC128S behaviour: the channel commanded in one frame is returned in the
    // next frame, as a 16-bit word whose upper nibble carries no data.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_win      = 1'b0;
            MISO        = 1'b0;
            adc_next_ch = 3'd0;
        end else begin
            if (!SS_n) begin
                if (!in_win) begin
                    in_win    = 1'b1;
                    win_len   = 0;
                    rises     = 0;
                    mosi_word = 16'h0000;
                    if (forced_mode)
                        miso_word = (forced_q.size() > 0) ? forced_q.pop_front() : 16'h0000;
                    else
                        miso_word = {4'($urandom), analog[adc_next_ch]};
                end
                win_len++;
                if (SCLK && !prev_sclk) begin
                    if (rises < 16) mosi_word[15-rises] = MOSI;
                    rises++;
                end
                MISO = (rises < 16) ? miso_word[15-rises] : 1'b0;
            end else begin
                if (in_win) begin
                    win_len_q.push_back(win_len);
                    win_rise_q.push_back(rises);
                    win_cmd_q.push_back(mosi_word);
                    adc_next_ch = mosi_word[13:11];
                    in_win = 1'b0;
                end
                if (prev_ss && (SCLK !== prev_sclk)) idle_toggles++;
            end
        end
        prev_sclk = SCLK;
        prev_ss   = SS_n;
    end

    task automatic clear_mon();
        win_len_q.delete();
        win_rise_q.delete();
        win_cmd_q.delete();
    endtask

    // Leaves the bench half a cycle after the edge that accepted strt_cnv.
    task automatic start_conv(input logic [2:0] ch);
        @(negedge clk);
        chnnl    = ch;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
    endtask

    task automatic wait_cmplt(input int limit, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < limit && !ok) begin
            @(negedge clk);
            lat++;
            if (cnv_cmplt) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL rst_sclk: got %b want 1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
        checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL rst_cmplt: got %b want 0", cnv_cmplt); end
        checks++; if (res !== 12'h000) begin failures++; $display("FAIL rst_res: got %h want 000", res); end
        rst_n = 1'b1;
        clear_mon();
        idle_toggles = 0;
        repeat (2000) @(negedge clk);
        checks++; if (win_len_q.size() != 0) begin failures++; $display("FAIL idle_windows: got %0d want 0", win_len_q.size()); end
        checks++; if (idle_toggles != 0) begin failures++; $display("FAIL idle_sclk: got %0d toggles want 0", idle_toggles); end
        checks++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin failures++; $display("FAIL idle_lines: ss_n=%b sclk=%b want 1/1", SS_n, SCLK); end
    endtask

    task automatic test_single();
        int lat;
        bit ok;
        clear_mon();
        start_conv(3'd3);
        wait_cmplt(1500, lat, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout: no cnv_cmplt within 1500 clks"); end
        checks++; if (lat != 1058) begin failures++; $display("FAIL single_latency: got %0d want 1058", lat); end
        checks++; if (res !== 12'hA5C) begin failures++; $display("FAIL single_res: got %h want a5c", res); end
        checks++; if (win_len_q.size() != 2) begin failures++; $display("FAIL single_windows: got %0d want 2", win_len_q.size()); end
        for (int i = 0; i < win_len_q.size(); i++) begin
            checks++; if (win_len_q[i] != 521) begin failures++; $display("FAIL single_ss_len[%0d]: got %0d want 521", i, win_len_q[i]); end
            checks++; if (win_rise_q[i] != 16) begin failures++; $display("FAIL single_rises[%0d]: got %0d want 16", i, win_rise_q[i]); end
            checks++; if (win_cmd_q[i] !== 16'h1800) begin failures++; $display("FAIL single_cmd[%0d]: got %h want 1800", i, win_cmd_q[i]); end
        end
    endtask

    task automatic test_sweep();
        int lat;
        bit ok;
        logic [15:0] cmd;
        for (int ch = 0; ch < 8; ch++) begin
            clear_mon();
            cmd = {2'b00, 3'(ch), 11'h000};
            start_conv(3'(ch));
            checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL sweep_clear ch%0d: got %b want 0", ch, cnv_cmplt); end
            wait_cmplt(1500, lat, ok);
            repeat (2) @(negedge clk);
            checks++; if (!ok) begin failures++; $display("FAIL sweep_timeout ch%0d", ch); end
            checks++; if (res !== analog[ch]) begin failures++; $display("FAIL sweep_res ch%0d: got %h want %h", ch, res, analog[ch]); end
            checks++; if (win_cmd_q.size() != 2) begin failures++; $display("FAIL sweep_windows ch%0d: got %0d want 2", ch, win_cmd_q.size()); end
            for (int i = 0; i < win_cmd_q.size(); i++) begin
                checks++; if (win_cmd_q[i] !== cmd) begin failures++; $display("FAIL sweep_cmd ch%0d[%0d]: got %h want %h", ch, i, win_cmd_q[i], cmd); end
            end
        end
    endtask

    task automatic test_miso_pattern();
        int lat;
        bit ok;
        forced_mode = 1'b1;
        forced_q = '{16'hFFFF, 16'hF123};
        clear_mon();
        start_conv(3'($urandom));
        wait_cmplt(1500, lat, ok);
        repeat (2) @(negedge clk);
        forced_mode = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL pattern_timeout"); end
        checks++; if (res !== 12'h123) begin failures++; $display("FAIL pattern_res: got %h want 123", res); end
        checks++; if (forced_q.size() != 0) begin failures++; $display("FAIL pattern_frames: %0d words unused want 0", forced_q.size()); end
    endtask

    task automatic test_ignored_start();
        int lat, t1, tg;
        bit ok;
        clear_mon();
        t1 = $urandom_range(30, 500);
        tg = $urandom_range(522, 537);
        start_conv(3'd2);
        repeat (t1 - 1) @(negedge clk);
        chnnl = 3'd5; strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (tg - t1 - 1) @(negedge clk);
        chnnl = 3'd5; strt_cnv = 1'b1;
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL ignore_gap_ss_n: got %b want 1", SS_n); end
        @(negedge clk);
        strt_cnv = 1'b0;
        wait_cmplt(1500, lat, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL ignore_timeout"); end
        checks++; if (res !== analog[2]) begin failures++; $display("FAIL ignore_res: got %h want %h", res, analog[2]); end
        checks++; if (win_cmd_q.size() != 2) begin failures++; $display("FAIL ignore_windows: got %0d want 2", win_cmd_q.size()); end
        for (int i = 0; i < win_cmd_q.size(); i++) begin
            checks++; if (win_cmd_q[i] !== 16'h1000) begin failures++; $display("FAIL ignore_cmd[%0d]: got %h want 1000", i, win_cmd_q[i]); end
        end
        repeat (1200) @(negedge clk);
        checks++; if (win_cmd_q.size() != 2) begin failures++; $display("FAIL ignore_extra_frames: got %0d want 2", win_cmd_q.size()); end
        checks++; if (cnv_cmplt !== 1'b1) begin failures++; $display("FAIL ignore_cmplt_hold: got %b want 1", cnv_cmplt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        logic [2:0] ch;
        clear_mon();
        start_conv(3'($urandom));
        repeat (810) @(negedge clk);
        checks++; if (SS_n !== 1'b0) begin failures++; $display("FAIL mid_in_tx2: ss_n=%b want 0", SS_n); end
        rst_n = 1'b0;
        #1;
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL mid_rst_ss_n: got %b want 1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL mid_rst_sclk: got %b want 1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL mid_rst_mosi: got %b want 0", MOSI); end
        checks++; if (res !== 12'h000) begin failures++; $display("FAIL mid_rst_res: got %h want 000", res); end
        checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL mid_rst_cmplt: got %b want 0", cnv_cmplt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_mon();
        ch = 3'($urandom);
        start_conv(ch);
        wait_cmplt(1500, lat, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL mid_fresh_timeout"); end
        checks++; if (lat != 1058) begin failures++; $display("FAIL mid_fresh_latency: got %0d want 1058", lat); end
        checks++; if (res !== analog[ch]) begin failures++; $display("FAIL mid_fresh_res ch%0d: got %h want %h", ch, res, analog[ch]); end
        checks++; if (win_len_q.size() != 2) begin failures++; $display("FAIL mid_fresh_windows: got %0d want 2", win_len_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) analog[i] = 12'($urandom_range(1, 4095));
        analog[3] = 12'hA5C;
        test_reset();
        test_single();
        test_sweep();
        test_miso_pattern();
        test_ignored_start();
        test_reset_mid();
        checks++; if (idle_toggles != 0) begin failures++; $display("FAIL sclk_while_ss_high: got %0d toggles want 0", idle_toggles); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
